// File: rtl/mcp4921_pkg.sv
// Shared definitions for the MCP4921 SPI write path.
// Latency: n/a (types, constants and the frame-building helper only).
// Backpressure: n/a.
package mcp4921_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CS_LOW    = 3'd1,
    SHIFT     = 3'd2,
    CS_HOLD   = 3'd3,
    LDAC_WAIT = 3'd4,
    LDAC      = 3'd5
  } state_t;

  localparam int FRAME_BITS = 16;

  localparam int BIT_AB   = 15;
  localparam int BIT_BUF  = 14;
  localparam int BIT_GA   = 13;
  localparam int BIT_SHDN = 12;

  // MCP4921 write command: channel A, config bits, then the 12-bit code.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic        buf_en,
    input logic        gain_1x,
    input logic        shdn_n,
    input logic [11:0] code
  );
    logic [FRAME_BITS-1:0] f;
    f           = '0;
    f[BIT_AB]   = 1'b0;
    f[BIT_BUF]  = buf_en;
    f[BIT_GA]   = gain_1x;
    f[BIT_SHDN] = shdn_n;
    f[11:0]     = code;
    return f;
  endfunction

endpackage

// File: rtl/spidac_tick_gen.sv
// Periodic tick: one-cycle pulse every DIV clk cycles, realignable by restart.
// Latency: first tick DIV cycles after restart is sampled. Ports: clk, rst_n, restart, tick.
// Backpressure: none; free-running between restarts.
module spidac_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = $clog2(DIV) + 1;
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Registered count, so tick is glitch-free and never feeds back on restart.
  assign tick = (cnt == '0);

endmodule

// File: rtl/mcp4921_spi_serializer.sv
// Serializes one 16-bit MCP4921 write frame (SPI mode 0,0, MSB first) per load edge, then pulses nLDAC.
// Latency: nCS falls 1 cycle after the edge; done at 1+34*CLK_DIV+LDAC_WIDTH. Ports: clk/nres, data+config, load -> busy/done/overrun, SCK/nCS/nLDAC/SDI.
// Backpressure: load edges arriving while busy are dropped and flagged on overrun.
module mcp4921_spi_serializer
  import mcp4921_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int LDAC_WIDTH = 2
) (
  input  logic        clk,
  input  logic        nres,
  input  logic [11:0] data,
  input  logic        buf_en,
  input  logic        gain_1x,
  input  logic        shdn_n,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        SCK,
  output logic        nCS,
  output logic        nLDAC,
  output logic        SDI
);

  localparam int LW = $clog2(LDAC_WIDTH) + 1;
  localparam logic [LW-1:0] LDAC_RELOAD = LW'(LDAC_WIDTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic                  load_q;
  logic                  load_rise;
  logic                  tick;
  logic                  restart;
  logic [FRAME_BITS-1:0] frame_word;
  // Bits still to be sent after the one currently on SDI.
  logic [FRAME_BITS-2:0] sr;
  logic [3:0]            bit_cnt;
  logic [LW-1:0]         ldac_cnt;

  assign load_rise  = load && !load_q;
  assign frame_word = build_frame(buf_en, gain_1x, shdn_n, data);
  // Realign the half-period timer on every state entry.
  assign restart    = (state_nxt != state);

  spidac_tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (nres),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (load_rise) state_nxt = CS_LOW;
      CS_LOW:    if (tick) state_nxt = SHIFT;
      // Leave SHIFT on the falling SCK edge of the final bit.
      SHIFT:     if (tick && SCK && (bit_cnt == '0)) state_nxt = CS_HOLD;
      CS_HOLD:   if (tick) state_nxt = LDAC_WAIT;
      LDAC_WAIT: if (tick) state_nxt = LDAC;
      LDAC:      if (ldac_cnt == '0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state    <= IDLE;
      load_q   <= 1'b0;
      sr       <= '0;
      bit_cnt  <= '0;
      ldac_cnt <= '0;
      SCK      <= 1'b0;
      nCS      <= 1'b1;
      nLDAC    <= 1'b1;
      SDI      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state   <= state_nxt;
      load_q  <= load;
      done    <= 1'b0;
      overrun <= load_rise && (state != IDLE);
      case (state)
        IDLE: begin
          if (load_rise) begin
            sr      <= frame_word[FRAME_BITS-2:0];
            SDI     <= frame_word[FRAME_BITS-1];
            bit_cnt <= 4'(FRAME_BITS - 1);
            nCS     <= 1'b0;
            busy    <= 1'b1;
          end
        end
        CS_LOW: begin
          // End of bit 15's low half-period: first rising edge.
          if (tick) SCK <= 1'b1;
        end
        SHIFT: begin
          if (tick) begin
            if (!SCK) begin
              SCK <= 1'b1;
            end else begin
              SCK <= 1'b0;
              if (bit_cnt == '0) begin
                SDI <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
                SDI     <= sr[FRAME_BITS-2];
                sr      <= {sr[FRAME_BITS-3:0], 1'b0};
              end
            end
          end
        end
        CS_HOLD: begin
          if (tick) nCS <= 1'b1;
        end
        LDAC_WAIT: begin
          if (tick) begin
            nLDAC    <= 1'b0;
            ldac_cnt <= LDAC_RELOAD;
          end
        end
        LDAC: begin
          if (ldac_cnt == '0) begin
            nLDAC <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            ldac_cnt <= ldac_cnt - 1'b1;
          end
        end
        default: begin
          nCS   <= 1'b1;
          nLDAC <= 1'b1;
          SCK   <= 1'b0;
          SDI   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
